serial_full_subtractor: RTL
===========================

Name: serial_full_subtractor

Overview:
Bit-serial subtraction engine, the inverse-operation counterpart of the team's adder cells. It computes diff = a - b - bin over WIDTH-bit operands using a single full-subtractor cell and a registered borrow, processing one bit per clock, LSB first. A start/busy/done handshake launches each operation and reports completion. It serves as a compact arithmetic unit in area-constrained datapaths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  launch request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
bin  input  1  borrow-in, captured on accepted start
busy  output  1  high while in SHIFT
done  output  1  single-cycle completion pulse
diff  output  WIDTH  result; updated only at completion
bout  output  1  final borrow-out; updated only at completion

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, diff=0, bout=0; internal shift registers, borrow flop and bit counter cleared. Reset overrides every other input, including start on the same edge.
- Reset mid-operation: the operation is abandoned. No done pulse. Outputs return to reset values.
- States:
  - IDLE: waiting for start.
  - SHIFT: one bit processed per cycle.
  - DONE: result presented for one cycle.
- IDLE -> SHIFT on an edge with start=1:
  - a, b captured into shift registers; borrow flop <= bin; counter <= 0; busy=1 from that edge.
- SHIFT, each edge:
  - x=a_sh[0], y=b_sh[0], r=borrow.
  - d = x^y^r.
  - borrow <= (~x & y) | (~(x^y) & r).
  - d shifted into the result shift register from the MSB side; a_sh and b_sh shifted right; counter++.
  - On the edge where counter==WIDTH-1, go to DONE: diff <= final result shift-register value (including this bit); bout <= final borrow; busy <= 0; done <= 1.
- DONE: done=1 for exactly one cycle.
  - Next edge with start=0: go to IDLE, done <= 0.
  - Next edge with start=1: new operation accepted, direct to SHIFT, done <= 0 (back-to-back supported).
- Latency: start sampled at edge k. Result bits are processed at edges k+1..k+WIDTH. diff, bout and done are valid after edge k+WIDTH. busy is high for exactly WIDTH cycles.
- start while busy: ignored; operands are not re-captured and the operation is unaffected.
- a, b and bin may change freely after the capture edge.
- diff and bout hold their last result until the next completion or reset.
- Arithmetic: diff = (a - b - bin) mod 2^WIDTH. bout=1 exactly when a < b + bin, evaluated as unsigned, unbounded.
- WIDTH=1: busy for one cycle; behaves as a registered full subtractor.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0, 1-cycle start -> busy high for 8 cycles; done pulses once after edge k+8; diff=0x02, bout=0.
2. a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x01, bin=1 -> diff=0x7E, bout=0.
3. Exhaustive WIDTH=1 sweep over all 8 (a,b,bin) combinations -> diff and bout match the full-subtractor truth table, e.g. (0,1,1) -> diff=0, bout=1; (1,0,0) -> diff=1, bout=0.
4. start held high continuously, with operands changed mid-operation -> first operation's result is unaffected. The next op is accepted in the DONE cycle with no IDLE gap, and done pulses every 9 cycles.
5. rst_n=0 at cycle 4 of SHIFT -> after that edge busy=0, done=0, diff=0x00, bout=0; no done pulse follows. A fresh start then completes correctly.
6. Random regression, WIDTH=8 and WIDTH=32, 1000 operations -> diff and bout match the reference model (a - b - bin) for every op; done count equals accepted-start count.

Source files
------------

// File: rtl/serial_full_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock LSB first,
// using a single full-subtractor cell and a registered borrow.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             borrow_next;
  logic             d_bit;
  logic             last;
  logic [CW-1:0]    cnt;

  // Full-subtractor cell on the current LSBs; the new bit enters at the MSB
  // so that after WIDTH shifts the result lands in natural bit order.
  always_comb begin
    d_bit       = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    res_next    = (res_sh >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
    last        = (cnt == LAST);
  end

  // NOTE: every output of a combinational block gets a default before the
  // case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_SHIFT;
      S_SHIFT: if (last) state_next = S_DONE;
      S_DONE:  state_next = start ? S_SHIFT : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the datapath registers are few and small, so all of them are
  // cleared by reset; this keeps diff/bout defined after an aborted operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          borrow <= borrow_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            diff <= res_next;
            bout <= borrow_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
